// File: rtl/hash_mmio_ctrl.sv
// Host MMIO wrapper for iterative hash cores with a queue of committed message blocks.
// Optional level interrupt and IRQ_EN register are built when HASH_MMIO_IRQ_EN is defined.
//
// state   | meaning
// S_IDLE  | waiting for a queued block and a ready core
// S_ISSUE | one cycle: init/next pulse for the head block
// S_ACK   | waiting for the core to drop ready
// S_BUSY  | core hashing; on ready, capture digest and pop the head slot
module hash_mmio_ctrl #(
    parameter int          BLOCK_WORDS  = 16,
    parameter int          DIGEST_WORDS = 5,
    parameter int          NUM_BUFS     = 2,
    parameter logic [31:0] NAME0        = 32'h73686131,
    parameter logic [31:0] NAME1        = 32'h20202020,
    parameter logic [31:0] VERSION      = 32'h302e3230
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cs,
    input  logic                      we,
    input  logic [7:0]                address,
    input  logic [31:0]               write_data,
    output logic [31:0]               read_data,
    output logic                      error,
    output logic                      irq,
    output logic                      core_init,
    output logic                      core_next,
    output logic [BLOCK_WORDS*32-1:0] core_block,
    input  logic                      core_ready,
    input  logic [DIGEST_WORDS*32-1:0] core_digest,
    input  logic                      core_digest_valid
);
    localparam int          PW       = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
    localparam int          BW       = BLOCK_WORDS * 32;
    localparam int          DW       = DIGEST_WORDS * 32;
    localparam logic [2:0]  CNT_FULL = 3'(NUM_BUFS);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_BUFS - 1);
    localparam logic [7:0]  A_STG_END = 8'(8'h10 + BLOCK_WORDS);
    localparam logic [7:0]  A_DIG_END = 8'(8'h20 + DIGEST_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK, S_BUSY} state_t;

    state_t              r_state, w_state_nxt;
    logic [31:0]         r_stage [BLOCK_WORDS];
    logic [BW-1:0]       r_q_blk [NUM_BUFS];
    logic [NUM_BUFS-1:0] r_q_first;
    logic [PW-1:0]       r_head, r_tail;
    logic [2:0]          r_count;
    logic [DW-1:0]       r_digest;
    logic                r_dvalid, r_overrun;
`ifdef HASH_MMIO_IRQ_EN
    logic                r_irq_pending, r_irq_en, r_irq;
    logic                w_irqen_we;
`endif

    logic [BW-1:0] w_stage_flat;
    logic [31:0]   w_rdata;
    logic          w_err, w_stage_we, w_ctrl_we, w_full, w_idle;
    logic          w_commit, w_reject, w_clear, w_pop, w_init, w_next;
    logic          w_unused_dbg;

    assign w_unused_dbg = core_digest_valid;
    assign w_full       = (r_count == CNT_FULL);
    assign w_idle       = (r_state == S_IDLE) && (r_count == 3'd0);
    assign w_commit     = w_ctrl_we & write_data[1] & ~w_full;
    assign w_reject     = w_ctrl_we & write_data[1] & w_full;
    assign w_clear      = w_ctrl_we & write_data[2] & ~w_err;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_stage_flat = '0;
        for (int i = 0; i < BLOCK_WORDS; i++)
            w_stage_flat[(BLOCK_WORDS-1-i)*32 +: 32] = r_stage[i];
    end

    always_comb begin
        w_rdata    = '0;
        w_err      = 1'b0;
        w_stage_we = 1'b0;
        w_ctrl_we  = 1'b0;
`ifdef HASH_MMIO_IRQ_EN
        w_irqen_we = 1'b0;
`endif
        if (cs) begin
            if (address == 8'h00) begin
                w_err = we; w_rdata = NAME0;
            end else if (address == 8'h01) begin
                w_err = we; w_rdata = NAME1;
            end else if (address == 8'h02) begin
                w_err = we; w_rdata = VERSION;
            end else if (address == 8'h08) begin
                w_ctrl_we = we;
                w_err     = we & write_data[1] & w_full;
            end else if (address == 8'h09) begin
                w_err   = we;
                w_rdata = {25'b0, r_count, r_overrun, w_full, r_dvalid, w_idle};
`ifdef HASH_MMIO_IRQ_EN
            end else if (address == 8'h0a) begin
                w_irqen_we = we;
                w_rdata    = {31'b0, r_irq_en};
`endif
            end else if (address >= 8'h10 && address < A_STG_END) begin
                w_stage_we = we;
                w_rdata    = r_stage[address[3:0]];
            end else if (address >= 8'h20 && address < A_DIG_END) begin
                w_err   = we;
                w_rdata = r_digest[(DIGEST_WORDS-1-int'(address[2:0]))*32 +: 32];
            end else begin
                w_err = 1'b1;
            end
            if (we || w_err)
                w_rdata = '0;
        end
    end

    assign read_data  = w_rdata;
    assign error      = w_err;
    assign core_block = r_q_blk[r_head];
    assign core_init  = w_init;
    assign core_next  = w_next;

    always_comb begin
        w_state_nxt = r_state;
        w_init      = 1'b0;
        w_next      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE:  if (r_count != 3'd0 && core_ready) w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                w_init      = r_q_first[r_head];
                w_next      = ~r_q_first[r_head];
                w_state_nxt = S_ACK;
            end
            S_ACK:   if (!core_ready) w_state_nxt = S_BUSY;
            S_BUSY:  if (core_ready) begin
                w_pop       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BLOCK_WORDS; i++) r_stage[i] <= '0;
            for (int i = 0; i < NUM_BUFS; i++)    r_q_blk[i] <= '0;
            r_q_first <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_digest  <= '0;
            r_dvalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_stage_we)
                r_stage[address[3:0]] <= write_data;
            if (w_commit) begin
                r_q_blk[r_tail]   <= w_stage_flat;
                r_q_first[r_tail] <= write_data[0];
                r_tail            <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_digest <= core_digest;
                r_dvalid <= 1'b1;
                r_head   <= ptr_inc(r_head);
            end else if (r_state == S_ISSUE) begin
                r_dvalid <= 1'b0;
            end
            case ({w_commit, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_reject)     r_overrun <= 1'b1;
            else if (w_clear) r_overrun <= 1'b0;
        end
    end

`ifdef HASH_MMIO_IRQ_EN
    // Pending is raised only when a pop empties the queue, not when a commit refills it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_pending <= 1'b0;
            r_irq_en      <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            if (w_pop && r_count == 3'd1 && !w_commit) r_irq_pending <= 1'b1;
            else if (w_clear)                          r_irq_pending <= 1'b0;
            if (w_irqen_we) r_irq_en <= write_data[0];
            r_irq <= r_irq_pending & r_irq_en;
        end
    end
    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_hash_mmio_ctrl.sv
// Self-checking bench for hash_mmio_ctrl with a behavioural SHA-1 core model.
// Interrupt checks follow HASH_MMIO_IRQ_EN when it is defined for the build.
module tb_hash_mmio_ctrl;
    logic         clk = 1'b0, reset_n = 1'b0, cs = 1'b0, we = 1'b0;
    logic [7:0]   address = '0;
    logic [31:0]  write_data = '0, read_data;
    logic         error, irq, core_init, core_next, core_ready, core_digest_valid;
    logic [511:0] core_block;
    logic [159:0] core_digest;

`ifdef HASH_MMIO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    localparam logic [159:0] H0 = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] BLK_B0 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_B1 = {{15{32'h0}}, 32'h000001c0};
    localparam logic [159:0] DIG_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] DIG_TWO = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    always #5 clk = ~clk;

    hash_mmio_ctrl dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(read_data), .error(error), .irq(irq),
        .core_init(core_init), .core_next(core_next), .core_block(core_block),
        .core_ready(core_ready), .core_digest(core_digest),
        .core_digest_valid(core_digest_valid)
    );

    function automatic logic [159:0] sha1_comp(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t, x;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {x[30:0], x[31]};
        end
        a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    // Core model: 80-cycle busy window per init/next; hold forces ready low.
    logic         m_ready = 1'b1, core_hold = 1'b0;
    int           m_busy = 0, n_init = 0, n_next = 0;
    logic [159:0] m_state = '0;
    assign core_ready        = m_ready & ~core_hold;
    assign core_digest       = m_state;
    assign core_digest_valid = m_ready;

    always @(posedge clk) begin
        if (core_init) n_init <= n_init + 1;
        if (core_next) n_next <= n_next + 1;
        if (core_init || core_next) begin
            m_state <= sha1_comp(core_init ? H0 : m_state, core_block);
            m_busy  <= 80;
            m_ready <= 1'b0;
        end else if (m_busy > 1) begin
            m_busy <= m_busy - 1;
        end else if (m_busy == 1) begin
            m_busy  <= 0;
            m_ready <= 1'b1;
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] r, output logic e);
        @(negedge clk);
        cs = 1'b1; we = w; address = a; write_data = d;
        #1 r = read_data; e = error;
        @(posedge clk);
        #1 cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] mask, input logic [31:0] exp,
                      input string name);
        logic [31:0] r; logic e;
        access(1'b0, a, '0, r, e);
        chk({name, "_err"}, {31'b0, e}, 32'd0);
        chk(name, r & mask, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic exp_err,
                      input string name);
        logic [31:0] r; logic e;
        access(1'b1, a, d, r, e);
        chk(name, {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic load(input logic [511:0] blk);
        logic [31:0] r; logic e;
        for (int i = 0; i < 16; i++) access(1'b1, 8'(8'h10 + i), blk[511-32*i -: 32], r, e);
    endtask

    task automatic wait_status(input logic [31:0] mask, input logic [31:0] val, input int max,
                               input string name);
        logic [31:0] r; logic e; int n;
        n = 0;
        do begin
            access(1'b0, 8'h09, '0, r, e);
            n++;
        end while (((r & mask) != val) && n < max);
        chk(name, r & mask, val);
    endtask

    task automatic check_digest(input logic [159:0] dig, input string name);
        for (int i = 0; i < 5; i++) rd(8'(8'h20 + i), 32'hffffffff, dig[159-32*i -: 32], name);
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;
    vec_t vecs[16];

    initial begin
        int n, snap;
        logic [31:0] r; logic e;
        vecs[0]  = '{1'b0, 8'h00, 32'h0, 32'h73686131, 1'b0, "name0"};
        vecs[1]  = '{1'b0, 8'h01, 32'h0, 32'h20202020, 1'b0, "name1"};
        vecs[2]  = '{1'b0, 8'h02, 32'h0, 32'h302e3230, 1'b0, "version"};
        vecs[3]  = '{1'b0, 8'h09, 32'h0, 32'h00000001, 1'b0, "status_rst"};
        vecs[4]  = '{1'b0, 8'h20, 32'h0, 32'h00000000, 1'b0, "digest_rst"};
        vecs[5]  = '{1'b0, 8'h05, 32'h0, 32'h00000000, 1'b1, "unmapped05"};
        vecs[6]  = '{1'b0, 8'h30, 32'h0, 32'h00000000, 1'b1, "unmapped30"};
        vecs[7]  = '{1'b1, 8'h00, 32'h1, 32'h0, 1'b1, "wr_name0"};
        vecs[8]  = '{1'b1, 8'h09, 32'h1, 32'h0, 1'b1, "wr_status"};
        vecs[9]  = '{1'b1, 8'h20, 32'h1, 32'h0, 1'b1, "wr_digest"};
        vecs[10] = '{1'b1, 8'h10, 32'hdeadbeef, 32'h0, 1'b0, "wr_stage0"};
        vecs[11] = '{1'b0, 8'h10, 32'h0, 32'hdeadbeef, 1'b0, "rd_stage0"};
        vecs[12] = '{1'b0, 8'h1f, 32'h0, 32'h00000000, 1'b0, "rd_stage15"};
        vecs[13] = '{1'b0, 8'h25, 32'h0, 32'h00000000, 1'b1, "digest_end"};
        vecs[14] = '{1'b0, 8'h0a, 32'h0, 32'h00000000, !IRQ_ON, "irq_en_rd"};
        vecs[15] = '{1'b1, 8'h08, 32'h0, 32'h0, 1'b0, "ctrl_nop"};

        repeat (3) @(negedge clk);
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_outs", {28'b0, error, irq, core_init, core_next}, 32'h0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, r, e);
            chk({vecs[i].name, "_err"}, {31'b0, e}, {31'b0, vecs[i].exp_err});
            if (!vecs[i].we) chk(vecs[i].name, r, vecs[i].exp_rdata);
        end

        // Single block "abc": pulse lands in the cycle ending on the 2nd edge after commit.
        load(BLK_ABC);
        wr(8'h08, 32'h3, 1'b0, "commit_abc");
        @(negedge clk); chk("lat_c1", {30'b0, core_init, core_next}, 32'h0);
        @(negedge clk); chk("lat_c2", {30'b0, core_init, core_next}, 32'h2);
        @(negedge clk); chk("lat_c3", {30'b0, core_init, core_next}, 32'h0);
        wait_status(32'h1, 32'h1, 300, "abc_idle");
        check_digest(DIG_ABC, "abc_dig");
        rd(8'h09, 32'h2, 32'h2, "abc_dvalid");
        chk("abc_ninit", n_init, 1);

        // Two-block message with the second block queued while the first hashes.
        snap = n_init;
        n = n_next;
        load(BLK_B0);
        wr(8'h08, 32'h3, 1'b0, "commit_b0");
        rd(8'h09, 32'h70, 32'h10, "cnt1");
        load(BLK_B1);
        wr(8'h08, 32'h2, 1'b0, "commit_b1");
        rd(8'h09, 32'h70, 32'h20, "cnt2");
        wait_status(32'h70, 32'h10, 300, "cnt_back1");
        wait_status(32'h1, 32'h1, 300, "two_idle");
        rd(8'h09, 32'h70, 32'h0, "cnt0");
        chk("two_ninit", n_init - snap, 1);
        chk("two_nnext", n_next - n, 1);
        check_digest(DIG_TWO, "two_dig");

        // Overrun with the core held not-ready.
        @(negedge clk); core_hold = 1'b1;
        wr(8'h08, 32'h3, 1'b0, "ovr_c1");
        wr(8'h08, 32'h3, 1'b0, "ovr_c2");
        wr(8'h08, 32'h3, 1'b1, "ovr_c3_full");
        rd(8'h09, 32'hffffffff, 32'h2e, "ovr_status");
        wr(8'h08, 32'h4, 1'b0, "ovr_clear");
        rd(8'h09, 32'hffffffff, 32'h26, "ovr_cleared");
        @(negedge clk); core_hold = 1'b0;
        wait_status(32'h1, 32'h1, 600, "ovr_drain");

        // Interrupt on drain.
        wr(8'h08, 32'h4, 1'b0, "irq_pre_clear");
        wr(8'h0a, 32'h1, !IRQ_ON, "irq_en_wr");
        load(BLK_ABC);
        wr(8'h08, 32'h3, 1'b0, "irq_commit");
        n = 0;
        while (core_ready && n < 20) begin @(negedge clk); n++; end
        chk("irq_core_busy", {31'b0, core_ready}, 32'h0);
        n = 0;
        while (!core_ready && n < 200) begin @(negedge clk); n++; end
        chk("irq_core_done", {31'b0, core_ready}, 32'h1);
        chk("irq_p0", {31'b0, irq}, 32'h0);
        @(negedge clk); chk("irq_p1", {31'b0, irq}, 32'h0);
        @(negedge clk); chk("irq_p2", {31'b0, irq}, {31'b0, IRQ_ON});
        wr(8'h08, 32'h4, 1'b0, "irq_clear");
        @(negedge clk); @(negedge clk);
        chk("irq_cleared", {31'b0, irq}, 32'h0);
        check_digest(DIG_ABC, "irq_dig");

        // Reset while the core is busy.
        wr(8'h08, 32'h3, 1'b0, "rst_commit");
        n = 0;
        while (core_ready && n < 20) begin @(negedge clk); n++; end
        chk("rst_core_busy", {31'b0, core_ready}, 32'h0);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rd(8'h09, 32'hffffffff, 32'h1, "rst_mid_status");
        rd(8'h20, 32'hffffffff, 32'h0, "rst_mid_digest");
        rd(8'h10, 32'hffffffff, 32'h0, "rst_mid_stage");
        snap = n_init + n_next;
        repeat (150) @(negedge clk);
        chk("rst_no_pulse", n_init + n_next - snap, 0);
        load(BLK_ABC);
        wr(8'h08, 32'h3, 1'b0, "rst_recommit");
        wait_status(32'h1, 32'h1, 300, "rst_idle");
        check_digest(DIG_ABC, "rst_dig");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
